// File: rtl/abr_ram_pkg.sv
// Shared types and helpers for the abr 1r1w zeroizable RAM family.
package abr_ram_pkg;

    typedef enum logic [0:0] {
        ZEROIZE_IDLE  = 1'b0,
        ZEROIZE_CLEAR = 1'b1
    } abr_zeroize_state_e;

    localparam int ABR_RAM_MIN_LANES = 1;

    // Width of one write-strobe lane; a zero lane count degrades to one lane.
    function automatic int abr_lane_w(input int data_width, input int num_lanes);
        return (num_lanes >= ABR_RAM_MIN_LANES) ? (data_width / num_lanes) : data_width;
    endfunction

endpackage

// File: rtl/abr_ram_zeroize_ctrl.sv
// Zeroization sequencer: walks every address once writing zero and reports
// when the array is closed to normal accesses.
module abr_ram_zeroize_ctrl
    import abr_ram_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH = 4,
    parameter int NUM_LANES  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  zeroize_i,
    output logic                  busy_o,
    output logic                  accept_o,
    output logic                  flush_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic [DATA_WIDTH-1:0] clr_wdata_o,
    output logic [NUM_LANES-1:0]  clr_wstrb_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR_C = ADDR_WIDTH'(DEPTH - 1);

    abr_zeroize_state_e    state_r, state_s;
    logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
    logic                  busy_r, busy_s;

    // State, clear counter and busy flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ZEROIZE_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
        end
    end

    // Next-state logic; a zeroize request seen in CLEAR never restarts the walk
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        busy_s  = busy_r;
        case (state_r)
            ZEROIZE_IDLE: begin
                if (zeroize_i) begin
                    state_s = ZEROIZE_CLEAR;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ZEROIZE_IDLE;
                    cnt_s   = '0;
                    busy_s  = 1'b0;
                end
            end
            ZEROIZE_CLEAR: begin
                if (cnt_r == LAST_ADDR_C) begin
                    state_s = ZEROIZE_IDLE;
                    cnt_s   = '0;
                    busy_s  = 1'b0;
                end else begin
                    state_s = ZEROIZE_CLEAR;
                    cnt_s   = cnt_r + ADDR_WIDTH'(1);
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = ZEROIZE_IDLE;
                cnt_s   = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign busy_o      = busy_r;
    assign accept_o    = (state_r == ZEROIZE_IDLE) && !zeroize_i;
    assign flush_o     = (state_r == ZEROIZE_IDLE) && zeroize_i;
    assign clr_we_o    = (state_r == ZEROIZE_CLEAR);
    assign clr_addr_o  = cnt_r;
    assign clr_wdata_o = '0;
    assign clr_wstrb_o = '1;

endmodule

// File: rtl/abr_1r1w_zeroize_ram.sv
// Single-clock 1r1w RAM with lane strobes, optional write forwarding,
// optional output register and hardware zeroization.
module abr_1r1w_zeroize_ram
    import abr_ram_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 4,
    parameter int NUM_LANES  = 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int OUT_REG    = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  zeroize_i,
    output logic                  busy_o,
    input  logic                  we_i,
    input  logic [NUM_LANES-1:0]  wstrb_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
);

    localparam int                  LANE_W  = abr_lane_w(DATA_WIDTH, NUM_LANES);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    if ((DATA_WIDTH % NUM_LANES) != 0) begin : g_lane_check
        $error("abr_1r1w_zeroize_ram: DATA_WIDTH must be a multiple of NUM_LANES");
    end

`ifdef RV_FPGA_OPTIMIZE
    (* ram_style = "block" *)
`endif
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic                  accept_s, flush_s, clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;
    logic [DATA_WIDTH-1:0] clr_wdata_s;
    logic [NUM_LANES-1:0]  clr_wstrb_s;

    logic                  waddr_ok_s, raddr_ok_s, usr_we_s, usr_re_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [NUM_LANES-1:0]  mem_wstrb_s;
    logic [DATA_WIDTH-1:0] rd_word_s, rd_merged_s;
    logic                  st_valid_s;
    logic [DATA_WIDTH-1:0] st_data_s;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  rvalid_r;

    abr_ram_zeroize_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (NUM_LANES)
    ) u_zeroize_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .zeroize_i   (zeroize_i),
        .busy_o      (busy_o),
        .accept_o    (accept_s),
        .flush_o     (flush_s),
        .clr_we_o    (clr_we_s),
        .clr_addr_o  (clr_addr_s),
        .clr_wdata_o (clr_wdata_s),
        .clr_wstrb_o (clr_wstrb_s)
    );

    assign waddr_ok_s = ({1'b0, waddr_i} < DEPTH_C);
    assign raddr_ok_s = ({1'b0, raddr_i} < DEPTH_C);
    assign usr_we_s   = accept_s && we_i && waddr_ok_s;
    assign usr_re_s   = accept_s && re_i;

    // Write port mux: the clear sequencer owns the port while wiping
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        mem_wstrb_s = '0;
        if (clr_we_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_addr_s;
            mem_wdata_s = clr_wdata_s;
            mem_wstrb_s = clr_wstrb_s;
        end else begin
            mem_we_s    = usr_we_s;
            mem_addr_s  = waddr_i;
            mem_wdata_s = wdata_i;
            mem_wstrb_s = wstrb_i;
        end
    end

    // Lane-masked array write; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (mem_wstrb_s[l]) begin
                    mem_r[mem_addr_s][l*LANE_W +: LANE_W] <= mem_wdata_s[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read word with per-lane forwarding of a same-address write
    always_comb begin
        rd_word_s   = '0;
        rd_merged_s = '0;
        if (raddr_ok_s) begin
            rd_word_s = mem_r[raddr_i];
        end else begin
            rd_word_s = '0;
        end
        rd_merged_s = rd_word_s;
        if ((BYPASS != 0) && usr_we_s && (waddr_i == raddr_i)) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wstrb_i[l]) begin
                    rd_merged_s[l*LANE_W +: LANE_W] = wdata_i[l*LANE_W +: LANE_W];
                end else begin
                    rd_merged_s[l*LANE_W +: LANE_W] = rd_word_s[l*LANE_W +: LANE_W];
                end
            end
        end else begin
            rd_merged_s = rd_word_s;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] p1_data_r;
        logic                  p1_valid_r;

        // Extra read stage, emptied when a wipe begins
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                p1_data_r  <= '0;
                p1_valid_r <= 1'b0;
            end else if (flush_s) begin
                p1_data_r  <= '0;
                p1_valid_r <= 1'b0;
            end else begin
                p1_valid_r <= usr_re_s;
                if (usr_re_s) begin
                    p1_data_r <= rd_merged_s;
                end
            end
        end

        assign st_valid_s = p1_valid_r;
        assign st_data_s  = p1_data_r;
    end else begin : g_no_out_reg
        assign st_valid_s = usr_re_s;
        assign st_data_s  = rd_merged_s;
    end

    // Output register: holds the last result until a new read lands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else if (flush_s) begin
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= st_valid_s;
            if (st_valid_s) begin
                rdata_r <= st_data_s;
            end
        end
    end

    assign rdata_o  = rdata_r;
    assign rvalid_o = rvalid_r;

endmodule
